keypad_fnd_entry: RTL and testbench

Parametrised keypad-to-display entry block: scans a 3×4 matrix keypad, debounces each scan frame, and turns each accepted press into an edit of a DIGITS-wide numeric entry buffer. The buffer is shown on a time-multiplexed 7-segment FND. It is the next generation of the single-digit keypad/FND pair: multi-digit, debounced, with clear and backspace keys. It sits between the board keypad pins and the FND pins, and reports each accepted key to system logic.

---
 rtl/keypad_fnd_pkg.sv | 63 ++++++
 rtl/keypad_fnd_entry_if.sv | 21 ++
 rtl/keypad_fnd_entry_fnd_scan.sv | 50 +++++
 rtl/keypad_fnd_entry.sv | 186 ++++++++++++++++++
 tb/tb_keypad_fnd_entry.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/keypad_fnd_pkg.sv
// Shared constants and lookups for the keypad-to-FND entry block.
// Optional build macro: KEYPAD_FND_REPEAT_EN (auto-repeat of held keys).
package keypad_fnd_pkg;

  localparam logic [3:0] KEY_STAR  = 4'd10;
  localparam logic [3:0] KEY_HASH  = 4'd11;
  localparam logic [3:0] KEY_NONE  = 4'd15;
  localparam logic [3:0] KEY_BLANK = KEY_NONE;

  localparam int REPEAT_START = 64;
  localparam int REPEAT_RATE  = 16;

  typedef enum logic [1:0] {
    EDIT_NONE,
    EDIT_DIGIT,
    EDIT_CLEAR,
    EDIT_BACK
  } edit_t;

  // Segment pattern {dp,g,f,e,d,c,b,a}; anything that is not a digit is blank.
  function automatic logic [7:0] seg_lookup(input logic [3:0] code);
    logic [7:0] seg;
    case (code)
      4'd0:    seg = 8'h3f;
      4'd1:    seg = 8'h06;
      4'd2:    seg = 8'h5b;
      4'd3:    seg = 8'h4f;
      4'd4:    seg = 8'h66;
      4'd5:    seg = 8'h6d;
      4'd6:    seg = 8'h7d;
      4'd7:    seg = 8'h07;
      4'd8:    seg = 8'h7f;
      4'd9:    seg = 8'h6f;
      default: seg = 8'h00;
    endcase
    return seg;
  endfunction

  // Key code at a (row, column) position of the 3x4 keypad.
  function automatic logic [3:0] key_at(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] code;
    if (r == 2'd3) begin
      case (c)
        2'd0:    code = KEY_STAR;
        2'd1:    code = 4'd0;
        default: code = KEY_HASH;
      endcase
    end else begin
      code = 4'(r) * 4'd3 + 4'(c) + 4'd1;
    end
    return code;
  endfunction

  function automatic edit_t edit_of(input logic [3:0] code);
    edit_t op;
    if (code <= 4'd9)          op = EDIT_DIGIT;
    else if (code == KEY_STAR) op = EDIT_CLEAR;
    else if (code == KEY_HASH) op = EDIT_BACK;
    else                       op = EDIT_NONE;
    return op;
  endfunction

endpackage

// File: rtl/keypad_fnd_entry_if.sv
// Board-side pins and key report of the keypad-to-FND entry block.
// master: the entry block; slave: keypad/FND pins and system logic.
interface keypad_fnd_entry_if #(parameter int DIGITS = 4);
  logic [3:0]        row;
  logic [2:0]        col;
  logic              fnd_en;
  logic [DIGITS-1:0] fnd_sel;
  logic [7:0]        fnd_data;
  logic [3:0]        key_code;
  logic              key_valid;

  modport master (
    input  row,
    output col, fnd_en, fnd_sel, fnd_data, key_code, key_valid
  );

  modport slave (
    output row,
    input  col, fnd_en, fnd_sel, fnd_data, key_code, key_valid
  );
endinterface

// File: rtl/keypad_fnd_entry_fnd_scan.sv
// FND digit multiplexer: walks fnd_sel from bit 0 upward every FND_DIV cycles
// and drives the segment pattern of the selected buffer entry.
// Optional build macro: KEYPAD_FND_REPEAT_EN (not used in this file).
module fnd_scan
  import keypad_fnd_pkg::*;
#(
  parameter int DIGITS  = 4,
  parameter int FND_DIV = 1000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DIGITS*4-1:0]   digits_flat,
  output logic [DIGITS-1:0]     fnd_sel,
  output logic [7:0]            fnd_data
);

  localparam int FW = (FND_DIV > 1) ? $clog2(FND_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [FW-1:0] fnd_cnt;
  logic [IW-1:0] idx;
  logic [IW-1:0] idx_next;
  logic          digit_end;

  // Next digit index; data is looked up from it so fnd_data moves with fnd_sel.
  always_comb begin
    digit_end = (fnd_cnt == FW'(FND_DIV - 1));
    idx_next  = idx;
    if (digit_end) begin
      if (idx == IW'(DIGITS - 1)) idx_next = '0;
      else                        idx_next = idx + IW'(1);
    end
  end

  // Slot timer, select register and registered segment output.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fnd_cnt  <= '0;
      idx      <= '0;
      fnd_sel  <= DIGITS'(1);
      fnd_data <= 8'h00;
    end else begin
      fnd_cnt  <= digit_end ? '0 : fnd_cnt + FW'(1);
      idx      <= idx_next;
      fnd_sel  <= DIGITS'(1) << idx_next;
      fnd_data <= seg_lookup(digits_flat[idx_next*4 +: 4]);
    end
  end

endmodule

// File: rtl/keypad_fnd_entry.sv
// Keypad scanner, frame debounce and numeric entry buffer driving a muxed FND.
// Optional build macro: KEYPAD_FND_REPEAT_EN (auto-repeat of held digit/'#').
module keypad_fnd_entry
  import keypad_fnd_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 1000,
  parameter int FND_DIV  = 1000,
  parameter int DEBOUNCE = 4
) (
  input  logic                clk,
  input  logic                reset,
  keypad_fnd_entry_if.master  io
);

  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [SW-1:0]            scan_cnt;
  logic [2:0]               col;
  logic [1:0]               hit_cnt;
  logic [3:0]               hit_code;
  logic [3:0]               prev_code;
  logic [3:0]               stable_code;
  logic [3:0]               db_cnt;
  logic                     fire;
  logic [3:0]               fire_code;
  logic [DIGITS-1:0][3:0]   entry_buf;
  logic [DIGITS-1:0][3:0]   buf_next;
  logic [3:0]               key_code;
  logic                     key_valid;
  logic                     fnd_en;

  logic                     slot_end;
  logic                     frame_end;
  logic [1:0]               col_idx;
  logic [1:0]               row_idx;
  logic [2:0]               row_ones;
  logic [2:0]               hits_sum;
  logic [1:0]               hit_cnt_next;
  logic [3:0]               hit_code_next;
  logic [3:0]               frame_code;
  logic [3:0]               db_cnt_next;
  logic [3:0]               stable_next;
  logic                     press;
  logic                     rep_fire;

  // Per-slot row decode and frame-level code / debounce next state.
  always_comb begin
    slot_end  = (scan_cnt == SW'(SCAN_DIV - 1));
    frame_end = slot_end & col[2];
    col_idx   = col[0] ? 2'd0 : (col[1] ? 2'd1 : 2'd2);
    row_ones  = 3'(io.row[0]) + 3'(io.row[1]) + 3'(io.row[2]) + 3'(io.row[3]);
    row_idx   = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (io.row[i]) row_idx = 2'(i);
    end
    hits_sum      = 3'(hit_cnt) + row_ones;
    hit_cnt_next  = (hits_sum >= 3'd2) ? 2'd2 : hits_sum[1:0];
    hit_code_next = (row_ones == 3'd1) ? key_at(row_idx, col_idx) : hit_code;
    frame_code    = (hit_cnt_next == 2'd1) ? hit_code_next : KEY_NONE;
    if (frame_code != prev_code)          db_cnt_next = 4'd1;
    else if (db_cnt >= 4'(DEBOUNCE))      db_cnt_next = db_cnt;
    else                                  db_cnt_next = db_cnt + 4'd1;
    stable_next = (db_cnt_next == 4'(DEBOUNCE)) ? frame_code : stable_code;
    press       = (stable_code == KEY_NONE) && (stable_next != KEY_NONE);
  end

`ifdef KEYPAD_FND_REPEAT_EN
  logic [6:0] rep_cnt;
  logic       rep_ok;

  // A held digit or '#' keeps counting stable frames; '*' is excluded.
  always_comb begin
    rep_ok   = (stable_code != KEY_NONE) && (stable_code != KEY_STAR) &&
               (stable_next == stable_code);
    rep_fire = rep_ok && ((rep_cnt + 7'd1) == 7'(REPEAT_START));
  end

  // Repeat timer: first fire REPEAT_START frames after acceptance, then every REPEAT_RATE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rep_cnt <= '0;
    end else if (frame_end) begin
      if (!rep_ok)       rep_cnt <= '0;
      else if (rep_fire) rep_cnt <= 7'(REPEAT_START - REPEAT_RATE);
      else               rep_cnt <= rep_cnt + 7'd1;
    end
  end
`else
  assign rep_fire = 1'b0;
`endif

  // Column rotation and within-frame hit accumulation.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scan_cnt <= '0;
      col      <= 3'b001;
      hit_cnt  <= '0;
      hit_code <= KEY_NONE;
    end else if (slot_end) begin
      scan_cnt <= '0;
      col      <= {col[1:0], col[2]};
      if (frame_end) begin
        hit_cnt  <= '0;
        hit_code <= KEY_NONE;
      end else begin
        hit_cnt  <= hit_cnt_next;
        hit_code <= hit_code_next;
      end
    end else begin
      scan_cnt <= scan_cnt + SW'(1);
    end
  end

  // Frame debounce; a press (or repeat) is flagged for the following cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev_code   <= KEY_NONE;
      db_cnt      <= '0;
      stable_code <= KEY_NONE;
      fire        <= 1'b0;
      fire_code   <= KEY_NONE;
    end else if (frame_end) begin
      prev_code   <= frame_code;
      db_cnt      <= db_cnt_next;
      stable_code <= stable_next;
      fire        <= press | rep_fire;
      fire_code   <= stable_next;
    end else begin
      fire        <= 1'b0;
    end
  end

  // Buffer edit for the flagged key; entry 0 is the rightmost digit.
  always_comb begin
    buf_next = entry_buf;
    case (edit_of(fire_code))
      EDIT_DIGIT: begin
        for (int i = DIGITS - 1; i > 0; i--) buf_next[i] = entry_buf[i-1];
        buf_next[0] = fire_code;
      end
      EDIT_CLEAR: begin
        for (int i = 0; i < DIGITS; i++) buf_next[i] = KEY_BLANK;
      end
      EDIT_BACK: begin
        for (int i = 0; i < DIGITS - 1; i++) buf_next[i] = entry_buf[i+1];
        buf_next[DIGITS-1] = KEY_BLANK;
      end
      default: buf_next = entry_buf;
    endcase
  end

  // Registered key report, buffer update and display enable.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      key_valid <= 1'b0;
      key_code  <= KEY_NONE;
      entry_buf <= {DIGITS{KEY_BLANK}};
      fnd_en    <= 1'b0;
    end else begin
      key_valid <= fire;
      fnd_en    <= 1'b1;
      if (fire) begin
        key_code  <= fire_code;
        entry_buf <= buf_next;
      end
    end
  end

  fnd_scan #(
    .DIGITS  (DIGITS),
    .FND_DIV (FND_DIV)
  ) u_fnd_scan (
    .clk         (clk),
    .reset       (reset),
    .digits_flat (entry_buf),
    .fnd_sel     (io.fnd_sel),
    .fnd_data    (io.fnd_data)
  );

  assign io.col       = col;
  assign io.fnd_en    = fnd_en;
  assign io.key_code  = key_code;
  assign io.key_valid = key_valid;

endmodule

// File: tb/tb_keypad_fnd_entry.sv
// Directed bench for keypad_fnd_entry with a behavioural 3x4 keypad.
// Optional build macro: KEYPAD_FND_REPEAT_EN (changes the held-key event count).
module tb_keypad_fnd_entry;

  localparam int DIGITS = 4;
  localparam int FRAME  = 12;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [11:0] pressed = '0;
  int          total = 0;
  int          bad = 0;
  int          evt_cnt = 0;
  logic [3:0]  evt_last = 4'hf;

  keypad_fnd_entry_if #(.DIGITS(DIGITS)) bus ();

  keypad_fnd_entry #(
    .DIGITS   (DIGITS),
    .SCAN_DIV (4),
    .FND_DIV  (4),
    .DEBOUNCE (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .io    (bus)
  );

  always #5 clk = ~clk;

  // Keypad model: a closed switch connects its column drive to its row.
  assign bus.row[0] = |(pressed[2:0]  & bus.col);
  assign bus.row[1] = |(pressed[5:3]  & bus.col);
  assign bus.row[2] = |(pressed[8:6]  & bus.col);
  assign bus.row[3] = |(pressed[11:9] & bus.col);

  always @(negedge clk) begin
    if (bus.key_valid === 1'b1) begin
      evt_cnt  = evt_cnt + 1;
      evt_last = bus.key_code;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total = total + 1;
    if (got !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] key_mask(input logic [3:0] k);
    logic [11:0] one;
    one = 12'd1;
    if (k >= 4'd1 && k <= 4'd9) return one << (k - 4'd1);
    if (k == 4'd10) return one << 9;
    if (k == 4'd0)  return one << 10;
    if (k == 4'd11) return one << 11;
    return '0;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic enter(input logic [3:0] k);
    pressed = key_mask(k);
    tick(6 * FRAME);
    pressed = '0;
    tick(6 * FRAME);
  endtask

  task automatic chk_digit(input string tag, input int i, input logic [7:0] exp);
    logic [7:0] data;
    logic       seen;
    seen = 1'b0;
    data = 8'h00;
    for (int n = 0; n < 40 && !seen; n++) begin
      @(negedge clk);
      if (bus.fnd_sel == 4'(1 << i)) begin
        seen = 1'b1;
        data = bus.fnd_data;
      end
    end
    chk({tag, "_sel_seen"}, 32'(seen), 32'd1);
    chk(tag, 32'(data), 32'(exp));
  endtask

  initial begin
    int cyc;
    int base;

    // Reset values, with '1' already held so the first frame sees it.
    pressed = key_mask(4'd1);
    tick(3);
    chk("rst_col", 32'(bus.col), 32'h1);
    chk("rst_sel", 32'(bus.fnd_sel), 32'h1);
    chk("rst_data", 32'(bus.fnd_data), 32'h0);
    chk("rst_en", 32'(bus.fnd_en), 32'h0);
    chk("rst_code", 32'(bus.key_code), 32'hf);
    chk("rst_valid", 32'(bus.key_valid), 32'h0);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("en_first_edge", 32'(bus.fnd_en), 32'h1);
    cyc = 1;
    while (bus.key_valid !== 1'b1 && cyc < 200) begin
      @(posedge clk);
      cyc = cyc + 1;
      @(negedge clk);
    end
    chk("press_latency", 32'(cyc), 32'd49);
    @(negedge clk);
    chk("valid_one_cycle", 32'(bus.key_valid), 32'h0);
    tick(5 * FRAME);
    pressed = '0;
    tick(8 * FRAME);
    chk("one_evt_cnt", 32'(evt_cnt), 32'd1);
    chk("one_evt_code", 32'(evt_last), 32'd1);
    chk_digit("one_d0", 0, 8'h06);
    chk_digit("one_d1", 1, 8'h00);
    chk_digit("one_d3", 3, 8'h00);

    // Clear, then 1..5 into a 4-digit buffer: 1 falls off the left.
    base = evt_cnt;
    enter(4'd10);
    for (int k = 1; k <= 5; k++) enter(4'(k));
    chk("seq_evt_cnt", 32'(evt_cnt - base), 32'd6);
    chk_digit("seq_d0", 0, 8'h6d);
    chk_digit("seq_d1", 1, 8'h66);
    chk_digit("seq_d2", 2, 8'h4f);
    chk_digit("seq_d3", 3, 8'h5b);

    // '5' bouncing every frame never stabilises.
    base = evt_cnt;
    for (int f = 0; f < 6; f++) begin
      pressed = (f % 2 == 0) ? key_mask(4'd5) : '0;
      tick(FRAME);
    end
    pressed = '0;
    tick(6 * FRAME);
    chk("bounce_evt_cnt", 32'(evt_cnt - base), 32'd0);
    chk_digit("bounce_d0", 0, 8'h6d);
    chk_digit("bounce_d3", 3, 8'h5b);

    // Backspace after 1,2,3, then clear.
    enter(4'd10);
    enter(4'd1);
    enter(4'd2);
    enter(4'd3);
    enter(4'd11);
    chk("hash_code", 32'(evt_last), 32'd11);
    chk_digit("bs_d0", 0, 8'h5b);
    chk_digit("bs_d1", 1, 8'h06);
    chk_digit("bs_d2", 2, 8'h00);
    chk_digit("bs_d3", 3, 8'h00);
    enter(4'd10);
    chk("star_code", 32'(evt_last), 32'd10);
    for (int i = 0; i < DIGITS; i++) chk_digit($sformatf("clr_d%0d", i), i, 8'h00);

    // Two keys held together: no event until one is released.
    base = evt_cnt;
    pressed = key_mask(4'd4) | key_mask(4'd6);
    tick(10 * FRAME);
    chk("dual_evt_cnt", 32'(evt_cnt - base), 32'd0);
    pressed = key_mask(4'd4);
    tick(6 * FRAME);
    pressed = '0;
    tick(6 * FRAME);
    chk("dual_rel_cnt", 32'(evt_cnt - base), 32'd1);
    chk("dual_rel_code", 32'(evt_last), 32'd4);
    chk_digit("dual_d0", 0, 8'h66);

    // Reset after 7, 8 wipes everything, asserted part-way into a frame.
    enter(4'd10);
    enter(4'd7);
    enter(4'd8);
    chk_digit("pre_rst_d0", 0, 8'h7f);
    chk_digit("pre_rst_d1", 1, 8'h07);
    pressed = key_mask(4'd2);
    tick(2 * FRAME + 5);
    reset = 1'b0;
    tick(2);
    chk("mid_rst_en", 32'(bus.fnd_en), 32'h0);
    chk("mid_rst_col", 32'(bus.col), 32'h1);
    chk("mid_rst_code", 32'(bus.key_code), 32'hf);
    chk("mid_rst_sel", 32'(bus.fnd_sel), 32'h1);
    chk("mid_rst_data", 32'(bus.fnd_data), 32'h0);
    pressed = '0;
    reset = 1'b1;
    tick(6 * FRAME);
    for (int i = 0; i < DIGITS; i++) chk_digit($sformatf("post_rst_d%0d", i), i, 8'h00);

    // Long hold of '9'.
    base = evt_cnt;
    pressed = key_mask(4'd9);
    tick(90 * FRAME);
    pressed = '0;
    tick(6 * FRAME);
`ifdef KEYPAD_FND_REPEAT_EN
    chk("hold_evt_cnt", 32'(evt_cnt - base), 32'd3);
    chk_digit("hold_d0", 0, 8'h6f);
    chk_digit("hold_d2", 2, 8'h6f);
    chk_digit("hold_d3", 3, 8'h00);
`else
    chk("hold_evt_cnt", 32'(evt_cnt - base), 32'd1);
    chk_digit("hold_d0", 0, 8'h6f);
    chk_digit("hold_d1", 1, 8'h00);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
